dca_matrix_row_loader: RTL and testbench

Upstream feeder for the DCA matrix register: accepts a load command, pulls up to MATRIX_SIZE_PARA rows from a valid/ready row stream, and drives the register's row-move write port one row per cycle. Missing rows are zero-padded to a full matrix. An optional transpose pulse is issued after the last row. A done pulse then hands the loaded matrix to the compute datapath.

---
 rtl/dca_matrix_row_loader.sv | 154 +++++++++++++++
 tb/tb_dca_matrix_row_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dca_matrix_row_loader.sv
// Feeds the DCA matrix register: takes one load command, streams up to N rows
// into its row-move port, zero-pads to N rows, optionally pulses transpose, then done.
module dca_matrix_row_loader #(
  parameter int MATRIX_SIZE_PARA = 8,
  parameter int BW_TENSOR_SCALAR = 32,
  parameter int BW_TENSOR_ROW    = MATRIX_SIZE_PARA * BW_TENSOR_SCALAR,
  parameter int BW_ROW_COUNT     = $clog2(MATRIX_SIZE_PARA + 1)
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [BW_ROW_COUNT-1:0]  cmd_num_rows,
  input  logic                     cmd_transpose,
  input  logic                     sinput_valid,
  output logic                     sinput_ready,
  input  logic [BW_TENSOR_ROW-1:0] sinput_data,
  output logic                     move_wenable,
  output logic [BW_TENSOR_ROW-1:0] move_wdata_list,
  output logic                     transpose,
  output logic                     done,
  output logic                     busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PAD    = 3'd2,
    ST_XPOSE  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  localparam logic [BW_ROW_COUNT-1:0] N_CNT   = BW_ROW_COUNT'(MATRIX_SIZE_PARA);
  localparam logic [BW_ROW_COUNT-1:0] CNT_ONE = BW_ROW_COUNT'(1);

  state_t                   state_q, state_d;
  logic [BW_ROW_COUNT-1:0]  row_cnt_q, row_cnt_d;
  logic [BW_ROW_COUNT-1:0]  rows_req_q, rows_req_d;
  logic                     xpose_req_q, xpose_req_d;
  logic                     move_wenable_q, move_wenable_d;
  logic [BW_TENSOR_ROW-1:0] move_wdata_q, move_wdata_d;
  logic                     transpose_q, transpose_d;
  logic                     done_q, done_d;

  logic [BW_ROW_COUNT-1:0]  rows_clamped_s;
  logic [BW_ROW_COUNT-1:0]  row_cnt_inc_s;

  assign rows_clamped_s = (cmd_num_rows > N_CNT) ? N_CNT : cmd_num_rows;
  assign row_cnt_inc_s  = row_cnt_q + CNT_ONE;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q        <= ST_IDLE;
      row_cnt_q      <= '0;
      rows_req_q     <= '0;
      xpose_req_q    <= 1'b0;
      move_wenable_q <= 1'b0;
      move_wdata_q   <= '0;
      transpose_q    <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_cnt_q      <= row_cnt_d;
      rows_req_q     <= rows_req_d;
      xpose_req_q    <= xpose_req_d;
      move_wenable_q <= move_wenable_d;
      move_wdata_q   <= move_wdata_d;
      transpose_q    <= transpose_d;
      done_q         <= done_d;
    end
  end

  // Next-state and row bookkeeping
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    rows_req_d  = rows_req_q;
    xpose_req_d = xpose_req_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          rows_req_d  = rows_clamped_s;
          xpose_req_d = cmd_transpose;
          row_cnt_d   = '0;
          state_d     = (rows_clamped_s != '0) ? ST_LOAD : ST_PAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (sinput_valid) begin
          row_cnt_d = row_cnt_inc_s;
          if (row_cnt_inc_s == rows_req_q) begin
            if (rows_req_q < N_CNT) begin
              state_d = ST_PAD;
            end else begin
              state_d = xpose_req_q ? ST_XPOSE : ST_FINISH;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_PAD: begin
        row_cnt_d = row_cnt_inc_s;
        if (row_cnt_inc_s == N_CNT) begin
          state_d = xpose_req_q ? ST_XPOSE : ST_FINISH;
        end else begin
          state_d = ST_PAD;
        end
      end
      ST_XPOSE:  state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Values loaded into the output registers; wdata holds when no row is written
  always_comb begin
    move_wenable_d = 1'b0;
    move_wdata_d   = move_wdata_q;
    transpose_d    = 1'b0;
    done_d         = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (sinput_valid) begin
          move_wenable_d = 1'b1;
          move_wdata_d   = sinput_data;
        end else begin
          move_wenable_d = 1'b0;
        end
      end
      ST_PAD: begin
        move_wenable_d = 1'b1;
        move_wdata_d   = '0;
      end
      ST_XPOSE:  transpose_d = 1'b1;
      ST_FINISH: done_d      = 1'b1;
      default:   move_wenable_d = 1'b0;
    endcase
  end

  assign cmd_ready       = (state_q == ST_IDLE);
  assign sinput_ready    = (state_q == ST_LOAD);
  assign busy            = (state_q != ST_IDLE);
  assign move_wenable    = move_wenable_q;
  assign move_wdata_list = move_wdata_q;
  assign transpose       = transpose_q;
  assign done            = done_q;

endmodule

// File: tb/tb_dca_matrix_row_loader.sv
// Randomized bench for dca_matrix_row_loader: per command, a cycle timeline of
// expected outputs is derived from the stream valid pattern and compared each cycle.
module tb_dca_matrix_row_loader;
  localparam int N    = 4;
  localparam int SW   = 8;
  localparam int RW   = N * SW;
  localparam int CW   = $clog2(N + 1);
  localparam int MAXC = 64;

  logic          clk = 1'b0;
  logic          rstnn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_num_rows;
  logic          cmd_transpose;
  logic          sinput_valid;
  logic          sinput_ready;
  logic [RW-1:0] sinput_data;
  logic          move_wenable;
  logic [RW-1:0] move_wdata_list;
  logic          transpose;
  logic          done;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dca_matrix_row_loader #(
    .MATRIX_SIZE_PARA(N),
    .BW_TENSOR_SCALAR(SW)
  ) u_dut (
    .clk            (clk),
    .rstnn          (rstnn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_num_rows   (cmd_num_rows),
    .cmd_transpose  (cmd_transpose),
    .sinput_valid   (sinput_valid),
    .sinput_ready   (sinput_ready),
    .sinput_data    (sinput_data),
    .move_wenable   (move_wenable),
    .move_wdata_list(move_wdata_list),
    .transpose      (transpose),
    .done           (done),
    .busy           (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check_eq({tag, "_sinput_ready"}, 64'(sinput_ready), 64'd0);
    check_eq({tag, "_wenable"}, 64'(move_wenable), 64'd0);
    check_eq({tag, "_wdata"}, 64'(move_wdata_list), 64'd0);
    check_eq({tag, "_transpose"}, 64'(transpose), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic drive_idle();
    cmd_valid     = 1'b0;
    cmd_num_rows  = '0;
    cmd_transpose = 1'b0;
    sinput_valid  = 1'b0;
    sinput_data   = '0;
  endtask

  // vmode: 0 full rate, 1 alternating 1,0,1,0.., 2 random. Called at a negedge = cycle 0.
  task automatic run_cmd(input int nrows, input bit xp, input int vmode, input bit seq_data,
                         input bit hold_valid, input int abort_c);
    logic [RW-1:0] data  [MAXC];
    bit            vld   [MAXC];
    bit            e_we  [MAXC];
    logic [RW-1:0] e_row [MAXC];
    logic [RW-1:0] r;
    int k, h, last_hs, last_wr, done_c, n_wr;
    k = (nrows > N) ? N : nrows;
    for (int c = 0; c < MAXC; c++) begin
      case (vmode)
        0:       vld[c] = 1'b1;
        1:       vld[c] = (c % 2 == 1);
        default: vld[c] = (c > 30) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      if (seq_data) begin
        for (int b = 0; b < N; b++) r[b*SW +: SW] = SW'(N * (c - 1) + b + 1);
        data[c] = r;
      end else begin
        data[c] = RW'($urandom);
      end
      e_we[c]  = 1'b0;
      e_row[c] = '0;
    end
    h = 0;
    last_hs = 0;
    for (int c = 1; c < MAXC - 1; c++) begin
      if (vld[c] && h < k) begin
        e_we[c+1]  = 1'b1;
        e_row[c+1] = data[c];
        h++;
        last_hs = c;
      end
    end
    last_wr = last_hs + 1 + (N - k);
    for (int z = 0; z < N - k; z++) begin
      e_we[last_hs + 2 + z]  = 1'b1;
      e_row[last_hs + 2 + z] = '0;
    end
    done_c = last_wr + 1 + int'(xp);
    n_wr = 0;

    for (int c = 0; c <= done_c; c++) begin
      if (c == 0) begin
        check_eq("c0_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("c0_busy", 64'(busy), 64'd0);
        check_eq("c0_sinput_ready", 64'(sinput_ready), 64'd0);
        check_eq("c0_wenable", 64'(move_wenable), 64'd0);
        check_eq("c0_transpose", 64'(transpose), 64'd0);
      end else begin
        check_eq($sformatf("cmd_ready@%0d", c), 64'(cmd_ready), 64'(c == done_c));
        check_eq($sformatf("busy@%0d", c), 64'(busy), 64'(c < done_c));
        check_eq($sformatf("sinput_ready@%0d", c), 64'(sinput_ready), 64'(k > 0 && c <= last_hs));
        check_eq($sformatf("wenable@%0d", c), 64'(move_wenable), 64'(e_we[c]));
        if (e_we[c]) check_eq($sformatf("wdata@%0d", c), 64'(move_wdata_list), 64'(e_row[c]));
        check_eq($sformatf("transpose@%0d", c), 64'(transpose), 64'(xp && c == last_wr + 1));
        check_eq($sformatf("done@%0d", c), 64'(done), 64'(c == done_c));
        if (move_wenable) n_wr++;
      end
      if (c == abort_c) begin
        rstnn = 1'b0;
        #1;
        check_reset("abort");
        drive_idle();
        repeat (2) begin
          @(negedge clk);
          check_eq("abort_no_done", 64'(done), 64'd0);
          check_eq("abort_wenable", 64'(move_wenable), 64'd0);
        end
        rstnn = 1'b1;
        return;
      end
      if (c == done_c) break;
      cmd_valid     = (c == 0) || hold_valid || ($urandom_range(0, 2) == 0);
      cmd_num_rows  = (c == 0) ? CW'(nrows) : CW'($urandom_range(0, 7));
      cmd_transpose = (c == 0) ? xp : 1'($urandom_range(0, 1));
      sinput_valid  = (c == 0) ? 1'($urandom_range(0, 1)) : vld[c];
      sinput_data   = data[c];
      @(negedge clk);
    end
    check_eq("write_count", 64'(n_wr), 64'(N));
    drive_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit b2b;
    rstnn = 1'b0;
    drive_idle();
    #2;
    check_reset("reset");
    repeat (2) @(negedge clk);
    rstnn = 1'b1;
    @(negedge clk);
    check_reset("post_reset");

    run_cmd(4, 1'b0, 0, 1'b1, 1'b0, -1); @(negedge clk);
    run_cmd(2, 1'b1, 0, 1'b0, 1'b0, -1); @(negedge clk);
    run_cmd(0, 1'b0, 0, 1'b0, 1'b0, -1); @(negedge clk);
    run_cmd(4, 1'b0, 1, 1'b0, 1'b0, -1); @(negedge clk);
    run_cmd(7, 1'b0, 0, 1'b0, 1'b0, -1); @(negedge clk);
    run_cmd(4, 1'b0, 0, 1'b0, 1'b0, 3);  @(negedge clk);
    run_cmd(4, 1'b0, 0, 1'b0, 1'b0, -1); @(negedge clk);
    run_cmd(3, 1'b1, 0, 1'b0, 1'b1, -1);
    run_cmd(4, 1'b0, 2, 1'b0, 1'b0, -1); @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      b2b = 1'($urandom_range(0, 1));
      run_cmd(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
              1'b0, b2b, -1);
      if (!b2b) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
